cg_i2c_master: RTL and testbench

//  Single-master I2C controller; the initiator end of the coilgun's I2C control link.
//  A local command port starts one transaction: write N bytes (e.g. creg) or read N bytes (e.g. eflg/acc).

---
 rtl/cg_i2c_master_pkg.sv | 86 ++++++++
 rtl/cg_i2c_master_tick.sv | 30 +++
 rtl/cg_i2c_master.sv | 222 ++++++++++++++++++++++
 tb/tb_cg_i2c_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_i2c_master_pkg.sv
// Shared types and helpers for the cg_i2c_master controller.
// Line-drive encoding: a 1 in pull_t means "pull the open-drain line low".
package cg_i2c_master_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned NB_W   = 2;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_AACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [NB_W-1:0]   nbytes;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic scl;
        logic sda;
    } pull_t;

    // Left-align the N payload bytes so the first byte to send sits in [23:16].
    function automatic logic [DATA_W-1:0] align_wdata(logic [DATA_W-1:0] w, logic [NB_W-1:0] n);
        logic [DATA_W-1:0] r;
        case (n)
            2'd0:    r = '0;
            2'd1:    r = {w[7:0], 16'h0000};
            2'd2:    r = {w[15:0], 8'h00};
            default: r = w;
        endcase
        return r;
    endfunction

    // Line pull pattern for a given state/quarter.
    function automatic pull_t line_drive(state_t st, quarter_t q, logic tx_bit, logic last_byte);
        pull_t p;
        p = '{scl: 1'b0, sda: 1'b0};
        case (st)
            ST_START: begin
                p.sda = 1'b1;
                p.scl = (q != Q0);
            end
            ST_STOP: begin
                p.scl = (q == Q0);
                p.sda = (q == Q0) || (q == Q1);
            end
            ST_ADDR, ST_WDATA: begin
                p.scl = (q == Q0) || (q == Q1);
                p.sda = ~tx_bit;
            end
            ST_AACK, ST_WACK, ST_RDATA: begin
                p.scl = (q == Q0) || (q == Q1);
            end
            ST_RACK: begin
                p.scl = (q == Q0) || (q == Q1);
                p.sda = ~(last_byte ? NACK : ACK);
            end
            default: p = '{scl: 1'b0, sda: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cg_i2c_master_tick.sv
// Quarter-bit tick generator: one pulse every CLK_DIV enabled cycles.
// The count freezes while hold is set so a slave can stretch SCL.
module cg_i2c_master_tick #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic hold,
    output logic tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_end_c;

    assign at_end_c = (cnt == CNT_W'(CLK_DIV - 1));
    assign tick_c   = en && !hold && at_end_c;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !hold) begin
            cnt <= at_end_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cg_i2c_master.sv
// Single-master I2C controller: one command starts a START/addr/data/STOP
// transaction of 0..3 bytes; SCL/SDA are open-drain via output enables.
module cg_i2c_master
    import cg_i2c_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_go,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              I_rw,
    input  logic [NB_W-1:0]   I_nbytes,
    input  logic [DATA_W-1:0] I_wdata,
    output logic [DATA_W-1:0] O_rdata,
    output logic              O_busy,
    output logic              O_done,
    output logic              O_nack,
    input  logic              I_scl,
    output logic              O_scl,
    output logic              OE_scl,
    input  logic              I_sda,
    output logic              O_sda,
    output logic              OE_sda
);

    state_t            state, state_n;
    quarter_t          q, q_n;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [NB_W-1:0]   byte_cnt, byte_cnt_n;
    logic [BYTE_W-1:0] tx_sh, tx_sh_n;
    logic [DATA_W-1:0] wd_sh, wd_sh_n;
    logic              rw, rw_n;
    logic [DATA_W-1:0] rdata, rdata_n;
    logic              busy, busy_n;
    logic              done, done_n;
    logic              nack, nack_n;
    logic              oe_scl, oe_scl_n;
    logic              oe_sda, oe_sda_n;

    cmd_t              cmd_c;
    pull_t             pull_c;
    logic              accept_c;
    logic              tick_c;
    logic              bit_end_c;
    logic              hold_c;

    assign cmd_c = '{addr: I_addr, rw: I_rw, nbytes: I_nbytes, wdata: I_wdata};

    // Stretch: once SCL is released, wait for it to actually read high.
    assign hold_c = busy && !oe_scl && !I_scl;

    cg_i2c_master_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (I_clk),
        .rst    (I_rst),
        .clr    (accept_c),
        .en     (busy),
        .hold   (hold_c),
        .tick_c (tick_c)
    );

    assign bit_end_c = tick_c && (q == Q3);

    always_comb begin
        state_n    = state;
        q_n        = q;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        tx_sh_n    = tx_sh;
        wd_sh_n    = wd_sh;
        rw_n       = rw;
        rdata_n    = rdata;
        busy_n     = busy;
        done_n     = 1'b0;
        nack_n     = nack;
        accept_c   = 1'b0;

        if (tick_c) begin
            q_n = quarter_t'(q + 2'd1);
        end

        case (state)
            ST_IDLE: begin
                if (I_go && !busy) begin
                    accept_c   = 1'b1;
                    state_n    = ST_START;
                    q_n        = Q0;
                    bit_cnt_n  = '0;
                    byte_cnt_n = cmd_c.nbytes;
                    tx_sh_n    = {cmd_c.addr, cmd_c.rw};
                    wd_sh_n    = align_wdata(cmd_c.wdata, cmd_c.nbytes);
                    rw_n       = cmd_c.rw;
                    rdata_n    = '0;
                    nack_n     = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            ST_START: begin
                if (tick_c && (q == Q1)) begin
                    state_n = ST_ADDR;
                    q_n     = Q0;
                end
            end
            ST_ADDR, ST_WDATA: begin
                if (bit_end_c) begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    tx_sh_n   = {tx_sh[BYTE_W-2:0], 1'b0};
                    if (bit_cnt == BIT_W'(7)) begin
                        state_n = (state == ST_ADDR) ? ST_AACK : ST_WACK;
                    end
                end
            end
            ST_RDATA: begin
                if (bit_end_c) begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                    rdata_n   = {rdata[DATA_W-2:0], I_sda};
                    if (bit_cnt == BIT_W'(7)) begin
                        state_n = ST_RACK;
                    end
                end
            end
            ST_AACK: begin
                if (bit_end_c) begin
                    if (I_sda == NACK) begin
                        nack_n  = 1'b1;
                        state_n = ST_STOP;
                    end else if (byte_cnt == '0) begin
                        state_n = ST_STOP;
                    end else if (rw) begin
                        state_n = ST_RDATA;
                    end else begin
                        state_n = ST_WDATA;
                        tx_sh_n = wd_sh[DATA_W-1 -: BYTE_W];
                        wd_sh_n = {wd_sh[DATA_W-BYTE_W-1:0], 8'h00};
                    end
                end
            end
            ST_WACK: begin
                if (bit_end_c) begin
                    byte_cnt_n = byte_cnt - NB_W'(1);
                    if (I_sda == NACK) begin
                        nack_n  = 1'b1;
                        state_n = ST_STOP;
                    end else if (byte_cnt == NB_W'(1)) begin
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_WDATA;
                        tx_sh_n = wd_sh[DATA_W-1 -: BYTE_W];
                        wd_sh_n = {wd_sh[DATA_W-BYTE_W-1:0], 8'h00};
                    end
                end
            end
            ST_RACK: begin
                if (bit_end_c) begin
                    byte_cnt_n = byte_cnt - NB_W'(1);
                    state_n    = (byte_cnt == NB_W'(1)) ? ST_STOP : ST_RDATA;
                end
            end
            ST_STOP: begin
                if (tick_c && (q == Q2)) begin
                    state_n = ST_IDLE;
                    q_n     = Q0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                q_n     = Q0;
                busy_n  = 1'b0;
            end
        endcase

        pull_c   = line_drive(state_n, q_n, tx_sh_n[BYTE_W-1], byte_cnt_n == NB_W'(1));
        oe_scl_n = pull_c.scl;
        oe_sda_n = pull_c.sda;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= ST_IDLE;
            q        <= Q0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_sh    <= '0;
            wd_sh    <= '0;
            rw       <= 1'b0;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
            oe_scl   <= 1'b0;
            oe_sda   <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            tx_sh    <= tx_sh_n;
            wd_sh    <= wd_sh_n;
            rw       <= rw_n;
            rdata    <= rdata_n;
            busy     <= busy_n;
            done     <= done_n;
            nack     <= nack_n;
            oe_scl   <= oe_scl_n;
            oe_sda   <= oe_sda_n;
        end
    end

    assign O_rdata = rdata;
    assign O_busy  = busy;
    assign O_done  = done;
    assign O_nack  = nack;
    assign OE_scl  = oe_scl;
    assign OE_sda  = oe_sda;
    assign O_scl   = 1'b0;
    assign O_sda   = 1'b0;

endmodule

// File: tb/tb_cg_i2c_master.sv
// Bench for cg_i2c_master with an open-drain I2C slave model on pulled-up lines;
// each O_done is matched against a queued expectation of the whole transaction.
module tb_cg_i2c_master;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [6:0]  SLV_ADDR = 7'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [6:0]  addr = '0;
    logic        rw = 1'b0;
    logic [1:0]  nbytes = '0;
    logic [23:0] wdata = '0;
    logic [23:0] O_rdata;
    logic        O_busy, O_done, O_nack;
    logic        O_scl, OE_scl, O_sda, OE_sda;
    logic        scl_bus, sda_bus;

    logic        s_scl_low = 1'b0;
    logic        s_sda_low = 1'b0;

    assign scl_bus = ~(OE_scl | s_scl_low);
    assign sda_bus = ~(OE_sda | s_sda_low);

    always #5 clk = ~clk;

    cg_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .I_clk    (clk),
        .I_rst    (rst),
        .I_go     (go),
        .I_addr   (addr),
        .I_rw     (rw),
        .I_nbytes (nbytes),
        .I_wdata  (wdata),
        .O_rdata  (O_rdata),
        .O_busy   (O_busy),
        .O_done   (O_done),
        .O_nack   (O_nack),
        .I_scl    (scl_bus),
        .O_scl    (O_scl),
        .OE_scl   (OE_scl),
        .I_sda    (sda_bus),
        .O_sda    (O_sda),
        .OE_sda   (OE_sda)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          slv_nack_at = 0;
    logic        slv_stretch_en = 1'b0;
    logic [7:0]  slv_rd [3];
    int          slv_bit, slv_byte, slv_rises, slv_rx_cnt, slv_stretch_left, slv_stretch_err;
    logic [7:0]  slv_rx_sh, slv_tx;
    logic [31:0] slv_rx_bytes;
    logic [2:0]  slv_mack;
    logic        slv_addressed, slv_rd_mode, slv_rd_active, slv_stretched, slv_stretch_sda;
    logic        prev_scl, prev_sda;

    task automatic slave_clear();
        slv_bit = 0; slv_byte = 0; slv_rises = 0; slv_rx_cnt = 0;
        slv_rx_sh = '0; slv_tx = '0; slv_rx_bytes = '0; slv_mack = '0;
        slv_addressed = 1'b0; slv_rd_mode = 1'b0; slv_rd_active = 1'b0;
        slv_stretched = 1'b0; slv_stretch_err = 0; slv_stretch_left = 0;
        s_sda_low = 1'b0; s_scl_low = 1'b0;
    endtask

    always @(negedge clk) begin
        logic cur_scl, cur_sda;
        cur_scl = scl_bus;
        cur_sda = sda_bus;
        if (rst) begin
            slave_clear();
            cur_scl = 1'b1;
            cur_sda = 1'b1;
        end else begin
            if (s_scl_low) begin
                if (cur_sda !== slv_stretch_sda) slv_stretch_err++;
                slv_stretch_left--;
                if (slv_stretch_left == 0) s_scl_low = 1'b0;
            end
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                slave_clear();
            end else if (!prev_scl && cur_scl) begin
                slv_rises++;
                if (slv_bit < 8) begin
                    slv_rx_sh = {slv_rx_sh[6:0], cur_sda};
                    slv_bit++;
                end else if (slv_bit == 8) begin
                    if (slv_rd_mode && slv_byte >= 2) begin
                        slv_mack = {slv_mack[1:0], cur_sda};
                        if (cur_sda) slv_rd_active = 1'b0;
                    end
                    slv_bit = 9;
                end
            end else if (prev_scl && !cur_scl) begin
                if (slv_bit == 8) begin
                    if (slv_byte == 0) begin
                        slv_addressed = (slv_rx_sh[7:1] == SLV_ADDR);
                        slv_rd_mode   = slv_rx_sh[0];
                        slv_rd_active = slv_addressed && slv_rx_sh[0];
                        slv_rx_bytes  = {slv_rx_bytes[23:0], slv_rx_sh};
                        slv_rx_cnt++;
                        s_sda_low     = slv_addressed;
                    end else if (!slv_rd_mode) begin
                        slv_rx_bytes = {slv_rx_bytes[23:0], slv_rx_sh};
                        slv_rx_cnt++;
                        s_sda_low    = (slv_byte != slv_nack_at);
                    end else begin
                        s_sda_low = 1'b0;
                    end
                    slv_byte++;
                end else if (slv_bit == 9) begin
                    slv_bit   = 0;
                    s_sda_low = 1'b0;
                    if (slv_rd_active && slv_byte >= 1 && slv_byte <= 3) begin
                        slv_tx    = slv_rd[slv_byte-1];
                        s_sda_low = ~slv_tx[7];
                    end
                end else if (slv_bit >= 1 && slv_rd_active && slv_byte >= 1) begin
                    s_sda_low = ~slv_tx[3'(7 - slv_bit)];
                end
                if (slv_stretch_en && !slv_stretched && slv_byte == 0 && slv_bit == 3) begin
                    slv_stretched    = 1'b1;
                    s_scl_low        = 1'b1;
                    slv_stretch_left = 20;
                    slv_stretch_sda  = sda_bus;
                end
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [23:0] rdata;
        logic        nack;
        int          rx_cnt;
        logic [31:0] rx_bytes;
        logic [2:0]  mack;
        int          cyc;
        int          rises;
        logic        stretched;
    } exp_t;

    exp_t sb [$];

    function automatic exp_t mk(int id, logic [23:0] rd, logic nk, int rxc, logic [31:0] rxb,
                                logic [2:0] mk_ack, int cyc, int rises, logic st);
        exp_t e;
        e.id = id; e.rdata = rd; e.nack = nk; e.rx_cnt = rxc; e.rx_bytes = rxb;
        e.mack = mk_ack; e.cyc = cyc; e.rises = rises; e.stretched = st;
        return e;
    endfunction

    initial begin : monitor
        int   cyc;
        exp_t e;
        cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                cyc = 0;
            end else begin
                if (O_busy) cyc++;
                if (O_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(O_done), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("t%0d_rdata", e.id), 32'(O_rdata), 32'(e.rdata));
                        check($sformatf("t%0d_nack", e.id), 32'(O_nack), 32'(e.nack));
                        check($sformatf("t%0d_busy_low", e.id), 32'(O_busy), 32'(0));
                        check($sformatf("t%0d_rx_cnt", e.id), 32'(slv_rx_cnt), 32'(e.rx_cnt));
                        check($sformatf("t%0d_rx_bytes", e.id), slv_rx_bytes, e.rx_bytes);
                        check($sformatf("t%0d_master_ack", e.id), 32'(slv_mack), 32'(e.mack));
                        check($sformatf("t%0d_busy_cycles", e.id), 32'(cyc), 32'(e.cyc));
                        check($sformatf("t%0d_scl_rises", e.id), 32'(slv_rises), 32'(e.rises));
                        check($sformatf("t%0d_stretched", e.id), 32'(slv_stretched), 32'(e.stretched));
                        check($sformatf("t%0d_stretch_sda", e.id), 32'(slv_stretch_err), 32'(0));
                        check($sformatf("t%0d_bus_idle", e.id), 32'({scl_bus, sda_bus}), 32'(2'b11));
                    end
                    cyc = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_txn(input int id, input logic [6:0] a, input logic r, input logic [1:0] n,
                           input logic [23:0] wd, input exp_t e);
        int k;
        sb.push_back(e);
        @(negedge clk);
        go = 1'b1; addr = a; rw = r; nbytes = n; wdata = wd;
        @(posedge clk); #1;
        check($sformatf("t%0d_accept_busy", id), 32'(O_busy), 32'(1));
        check($sformatf("t%0d_accept_nack_clr", id), 32'(O_nack), 32'(0));
        check($sformatf("t%0d_accept_rdata_clr", id), 32'(O_rdata), 32'(0));
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (O_busy === 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("t%0d_timeout", id), 32'(O_busy), 32'(0));
        repeat (4) @(negedge clk);
    endtask

    initial begin : stim
        int dn;
        slv_rd[0] = 8'h33; slv_rd[1] = 8'h33; slv_rd[2] = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe_scl", 32'(OE_scl), 32'(0));
        check("rst_oe_sda", 32'(OE_sda), 32'(0));
        check("rst_busy", 32'(O_busy), 32'(0));
        check("rst_done", 32'(O_done), 32'(0));
        check("rst_nack", 32'(O_nack), 32'(0));
        check("rst_rdata", 32'(O_rdata), 32'(0));
        check("rst_drive_vals", 32'({O_scl, O_sda}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // write 1 byte
        run_txn(1, 7'h02, 1'b0, 2'd1, 24'h0000A5,
                mk(1, 24'h0, 1'b0, 2, 32'h0000_04A5, 3'b000, 308, 19, 1'b0));
        // read 3 bytes of 0x33
        run_txn(2, 7'h02, 1'b1, 2'd3, 24'h0,
                mk(2, 24'h333333, 1'b0, 1, 32'h05, 3'b001, 596, 37, 1'b0));
        // read 2 distinct bytes: order check
        slv_rd[0] = 8'hA1; slv_rd[1] = 8'h5C;
        run_txn(3, 7'h02, 1'b1, 2'd2, 24'h0,
                mk(3, 24'h00A15C, 1'b0, 1, 32'h05, 3'b001, 452, 28, 1'b0));
        // probe of absent address
        run_txn(4, 7'h05, 1'b0, 2'd0, 24'h0,
                mk(4, 24'h0, 1'b1, 1, 32'h0A, 3'b000, 164, 10, 1'b0));
        repeat (6) @(negedge clk);
        check("t4_nack_held", 32'(O_nack), 32'(1));
        // slave NACKs first data byte of two
        slv_nack_at = 1;
        run_txn(5, 7'h02, 1'b0, 2'd2, 24'h00BEEF,
                mk(5, 24'h0, 1'b1, 2, 32'h0000_04BE, 3'b000, 308, 19, 1'b0));
        slv_nack_at = 0;
        // clock stretch in address bit 3
        slv_stretch_en = 1'b1;
        run_txn(6, 7'h02, 1'b0, 2'd1, 24'h00003C,
                mk(6, 24'h0, 1'b0, 2, 32'h0000_043C, 3'b000, 320, 19, 1'b1));
        slv_stretch_en = 1'b0;

        // reset mid-read while go is held with a different command
        slv_rd[0] = 8'h33; slv_rd[1] = 8'h33; slv_rd[2] = 8'h33;
        @(negedge clk);
        go = 1'b1; addr = 7'h02; rw = 1'b1; nbytes = 2'd3;
        @(negedge clk);
        addr = 7'h05; rw = 1'b0;
        repeat (10) @(negedge clk);
        go = 1'b0;
        repeat (190) @(negedge clk);
        check("t7_busy_mid", 32'(O_busy), 32'(1));
        check("t7_addr_byte", slv_rx_bytes, 32'h05);
        check("t7_rx_cnt", 32'(slv_rx_cnt), 32'(1));
        check("t7_rdata_partial", 32'(O_rdata != 24'h0), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_oe_scl", 32'(OE_scl), 32'(0));
        check("t7_oe_sda", 32'(OE_sda), 32'(0));
        check("t7_busy", 32'(O_busy), 32'(0));
        check("t7_rdata", 32'(O_rdata), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (O_done) dn++;
        end
        check("t7_no_done", 32'(dn), 32'(0));
        check("t7_bus_idle", 32'({scl_bus, sda_bus}), 32'(2'b11));

        // recovery: write 3 bytes, MSB byte first
        run_txn(8, 7'h02, 1'b0, 2'd3, 24'h123456,
                mk(8, 24'h0, 1'b0, 4, 32'h0412_3456, 3'b000, 596, 37, 1'b0));

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
